// File: rtl/product_accumulator.sv
// Packet-wise product accumulator with a registered valid/ready result stage.
// Define ACC_SATURATE_EN to clamp the sum on overflow instead of wrapping.
module product_accumulator #(
    parameter int WIDTH     = 4,
    parameter int ACC_WIDTH = 12,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2*WIDTH-1:0]   in_product,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_sum,
    output logic [CNT_WIDTH-1:0] out_count,
    output logic                 out_overflow
);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        HOLD
    } state_t;

    state_t               state;
    logic [ACC_WIDTH-1:0] acc;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 ovf;

    logic                 accept;
    logic                 pop;
    logic [ACC_WIDTH:0]   sum_full;
    logic                 carry;
    logic [ACC_WIDTH-1:0] acc_nxt;
    logic [CNT_WIDTH-1:0] cnt_nxt;
    logic                 ovf_nxt;

    // A held result may drain and be refilled in the same cycle.
    assign in_ready = (state != HOLD) || out_ready;
    assign accept   = in_valid && in_ready;
    assign pop      = out_valid && out_ready;

    assign sum_full = {1'b0, acc}
                    + {{(ACC_WIDTH+1-2*WIDTH){1'b0}}, in_product};
    assign carry    = sum_full[ACC_WIDTH];
    assign ovf_nxt  = ovf | carry;
    assign cnt_nxt  = (&cnt) ? cnt : cnt + CNT_WIDTH'(1);

`ifdef ACC_SATURATE_EN
    assign acc_nxt = carry ? {ACC_WIDTH{1'b1}}
                           : sum_full[ACC_WIDTH-1:0];
`else
    assign acc_nxt = sum_full[ACC_WIDTH-1:0];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            acc          <= '0;
            cnt          <= '0;
            ovf          <= 1'b0;
            out_valid    <= 1'b0;
            out_sum      <= '0;
            out_count    <= '0;
            out_overflow <= 1'b0;
        end else begin
            if (pop) begin
                out_valid <= 1'b0;
            end
            // clear discards any beat accepted alongside it
            if (clear) begin
                acc <= '0;
                cnt <= '0;
                ovf <= 1'b0;
                if ((state == ACCUM) || pop) begin
                    state <= IDLE;
                end
            end else if (accept && in_last) begin
                out_sum      <= acc_nxt;
                out_count    <= cnt_nxt;
                out_overflow <= ovf_nxt;
                out_valid    <= 1'b1;
                acc          <= '0;
                cnt          <= '0;
                ovf          <= 1'b0;
                state        <= HOLD;
            end else if (accept) begin
                acc   <= acc_nxt;
                cnt   <= cnt_nxt;
                ovf   <= ovf_nxt;
                state <= ACCUM;
            end else if (pop) begin
                state <= IDLE;
            end
        end
    end

endmodule
